fetch_seq: RTL and testbench

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 164 ++++++++++++++++
 tb/tb_fetch_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// fetch_seq -- instruction fetch sequencer.
//
// Walks pc from 0 to PROG_LEN-1 against a 1-cycle-latency instruction memory.
// It presents each returned instruction to decode through an output register.
// A one-entry skid buffer holds the single in-flight return when decode stalls.
// Redirects restart fetch at a new pc, or finish the run if the target is
// past the program. halt aborts the run back to IDLE.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse: begin a run at pc 0 (from IDLE or DONE)
//   halt                abort the run and return to IDLE
//   stall               decode not ready; the held instruction is not consumed
//   redirect_valid/_pc  branch/flush request and its target
//   pc                  fetch address to instruction memory
//   instr_in            memory read data, valid one cycle after pc
//   instr_out/_pc/_valid instruction, its address and valid flag to decode
//   busy                high in RUN or DRAIN
//   done                high in DONE
module fetch_seq #(
    parameter int PROG_LEN = 8,
    parameter int INSTR_W  = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [7:0]         redirect_pc,
    output logic [7:0]         pc,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [7:0]         instr_pc,
    output logic               busy,
    output logic               done
);

    localparam logic [7:0] LAST_PC  = 8'(PROG_LEN - 1);
    localparam logic [8:0] PROG_END = 9'(PROG_LEN);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [7:0]          pc_nxt;
    logic                inflight;
    logic [7:0]          inflight_pc;
    logic                skid_valid;
    logic [INSTR_W-1:0]  skid_instr;
    logic [7:0]          skid_pc;

    logic active, flush, issue, load, target_ok;

    assign active    = (state == RUN) || (state == DRAIN);
    // halt and redirect both discard everything fetched so far
    assign flush     = active && (halt || redirect_valid);
    // No issue while the skid buffer is occupied: this caps outstanding
    // fetches at one, so the skid buffer can never overflow.
    assign issue     = (state == RUN) && !stall && !skid_valid && !redirect_valid && !halt;
    assign load      = !instr_valid || !stall;
    assign target_ok = ({1'b0, redirect_pc} < PROG_END);

    assign busy = active;
    assign done = (state == DONE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= 8'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE, DONE: begin
                if (start && !halt) begin
                    state_nxt = RUN;
                    pc_nxt    = 8'd0;
                end
            end
            RUN, DRAIN: begin
                if (halt) begin
                    state_nxt = IDLE;
                end else if (redirect_valid) begin
                    // An out-of-range target ends the run; pc stays in range.
                    if (target_ok) begin
                        state_nxt = RUN;
                        pc_nxt    = redirect_pc;
                    end else begin
                        state_nxt = DONE;
                    end
                end else if (state == RUN) begin
                    if (issue) begin
                        // pc holds at the last entry so it never leaves the program
                        if (pc == LAST_PC) state_nxt = DRAIN;
                        else               pc_nxt    = pc + 8'd1;
                    end
                end else if (!inflight && !skid_valid && !instr_valid) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- in-flight tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            inflight_pc <= 8'd0;
        end else begin
            inflight <= issue && !flush;
            if (issue) inflight_pc <= pc;
        end
    end

    // ---------------- skid buffer ----------------
    // Only a return arriving while decode holds a stalled instruction lands
    // here; it drains into the output register on the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= 8'd0;
        end else if (flush || load) begin
            skid_valid <= 1'b0;
        end else if (inflight) begin
            skid_valid <= 1'b1;
            skid_instr <= instr_in;
            skid_pc    <= inflight_pc;
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= 8'd0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (load) begin
            if (skid_valid) begin
                instr_valid <= 1'b1;
                instr_out   <= skid_instr;
                instr_pc    <= skid_pc;
            end else if (inflight) begin
                instr_valid <= 1'b1;
                instr_out   <= instr_in;
                instr_pc    <= inflight_pc;
            end else begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;
    localparam int P = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, halt = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'd0;
    logic [7:0]  pc;
    logic [17:0] instr_in = 18'd0;
    logic [17:0] instr_out;
    logic        instr_valid;
    logic [7:0]  instr_pc;
    logic        busy, done;

    fetch_seq #(.PROG_LEN(P), .INSTR_W(18)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc),
        .instr_in(instr_in), .instr_out(instr_out), .instr_valid(instr_valid),
        .instr_pc(instr_pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [17:0] mem [0:255];
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // instruction memory: 1-cycle read latency
    initial forever begin
        @(posedge clk);
        instr_in <= mem[pc];
    end

    // ---------------- behavioural model ----------------
    // The model keeps a queue of issued-but-not-presented addresses with their
    // age in cycles. An entry older than one cycle is one that decode
    // refused; it blocks further fetching until it is presented.
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
    typedef struct { logic [7:0] a; int age; } ent_t;
    ent_t       q[$];
    int         m_mode = M_IDLE;
    logic [7:0] m_pc = 0, m_opc = 0;
    bit         m_ov = 0;

    task automatic model_step();
        bit   running, waiting, iss, was_empty, was_ov;
        ent_t e;
        running   = (m_mode == M_RUN) || (m_mode == M_DRAIN);
        waiting   = 0;
        foreach (q[i]) if (q[i].age >= 1) waiting = 1;
        iss       = (m_mode == M_RUN) && !stall && !waiting && !redirect_valid && !halt;
        was_empty = (q.size() == 0);
        was_ov    = m_ov;
        if (running && (halt || redirect_valid)) begin
            q.delete();
            m_ov = 0;
            if (halt)                    m_mode = M_IDLE;
            else if (redirect_pc < P) begin m_mode = M_RUN; m_pc = redirect_pc; end
            else                         m_mode = M_DONE;
        end else begin
            if (!m_ov || !stall) begin
                if (q.size() > 0) begin e = q.pop_front(); m_opc = e.a; m_ov = 1; end
                else m_ov = 0;
            end
            foreach (q[i]) q[i].age++;
            if (iss) begin e.a = m_pc; e.age = 0; q.push_back(e); end
            case (m_mode)
                M_IDLE, M_DONE: if (start && !halt) begin m_mode = M_RUN; m_pc = 0; end
                M_RUN: if (iss) begin
                    if (m_pc == P - 1) m_mode = M_DRAIN;
                    else m_pc = m_pc + 1;
                end
                M_DRAIN: if (was_empty && !was_ov) m_mode = M_DONE;
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete(); m_mode = M_IDLE; m_pc = 0; m_opc = 0; m_ov = 0;
        end else model_step();
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("m_pc", pc, m_pc);
            chk("m_busy", busy, (m_mode == M_RUN || m_mode == M_DRAIN));
            chk("m_done", done, (m_mode == M_DONE));
            chk("m_valid", instr_valid, m_ov);
            if (m_ov && instr_valid) begin
                chk("m_instr_pc", instr_pc, m_opc);
                chk("m_instr_out", instr_out, mem[m_opc]);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick(); @(negedge clk); endtask
    task automatic start_run(); start = 1; tick(); start = 0; endtask
    task automatic halt_pulse(); halt = 1; tick(); halt = 0; endtask
    task automatic wait_vpc(input logic [7:0] k, input string nm);
        int n = 0;
        while (!(instr_valid && instr_pc == k) && n < 40) begin tick(); n++; end
        if (n >= 40) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        logic [7:0]  vpc [0:15];
        logic [17:0] vout [0:15];
        int nv, first, last, dcyc, gap, maxgap;

        for (int i = 0; i < 256; i++) mem[i] = 18'($urandom);
        mem[0] = 18'h06432;
        mem[1] = 18'h19678;

        // reset state
        repeat (2) tick();
        chk("rst_pc", pc, 0); chk("rst_valid", instr_valid, 0); chk("rst_out", instr_out, 0);
        chk("rst_ipc", instr_pc, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        rst_n = 1;

        // A: straight run
        start_run();
        nv = 0; first = -1; last = -1; dcyc = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 8) chk("A_pc", pc, c);
            if (instr_valid) begin
                if (nv < 16) begin vpc[nv] = instr_pc; vout[nv] = instr_out; end
                if (first < 0) first = c;
                last = c; nv++;
            end
            if (done && dcyc < 0) dcyc = c;
            tick();
        end
        chk("A_nvalid", nv, 8); chk("A_first", first, 2); chk("A_span", last - first, 7);
        for (int i = 0; i < 8; i++) chk("A_ipc", vpc[i], i);
        chk("A_out0", vout[0], 18'h06432); chk("A_out1", vout[1], 18'h19678);
        chk("A_done_cyc", dcyc, 11);

        // B: stall 3 cycles with instr_pc=2 held
        halt_pulse(); start_run();
        wait_vpc(2, "B_wait");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("B_hold_pc", instr_pc, 2); chk("B_hold_v", instr_valid, 1);
            chk("B_hold_out", instr_out, mem[2]); chk("B_pc_hold", pc, 4);
        end
        stall = 0; tick();
        nv = 0; gap = 0; maxgap = 0;
        for (int c = 0; c < 10; c++) begin
            if (instr_valid) begin
                if (nv < 16) vpc[nv] = instr_pc;
                nv++;
                if (gap > maxgap) maxgap = gap;
                gap = 0;
            end else if (nv > 0) gap++;
            tick();
        end
        chk("B_n", nv, 5); chk("B_maxgap", maxgap, 1);
        for (int i = 0; i < 5; i++) chk("B_seq", vpc[i], 3 + i);

        // C: redirect to 5 while instr_pc=1 valid
        halt_pulse(); start_run();
        wait_vpc(1, "C_wait");
        redirect_valid = 1; redirect_pc = 5; tick(); redirect_valid = 0;
        chk("C_flush_v", instr_valid, 0); chk("C_pc", pc, 5);
        nv = 0; first = -1; dcyc = -1;
        for (int c = 0; c < 12; c++) begin
            if (instr_valid) begin
                if (nv < 16) vpc[nv] = instr_pc;
                if (first < 0) first = c;
                nv++;
            end
            if (done && dcyc < 0) dcyc = c;
            tick();
        end
        chk("C_n", nv, 3); chk("C_first", first, 2); chk("C_done_cyc", dcyc, 6);
        for (int i = 0; i < 3; i++) chk("C_seq", vpc[i], 5 + i);

        // D: redirect past the program
        halt_pulse(); start_run();
        wait_vpc(0, "D_wait");
        redirect_valid = 1; redirect_pc = 9; tick(); redirect_valid = 0;
        chk("D_done", done, 1); chk("D_valid", instr_valid, 0); chk("D_busy", busy, 0);
        repeat (2) tick();
        chk("D_valid2", instr_valid, 0); chk("D_done2", done, 1);

        // E: asynchronous reset mid-run
        halt_pulse(); start_run();
        wait_vpc(4, "E_wait");
        #2 rst_n = 0;
        #1;
        chk("E_pc", pc, 0); chk("E_valid", instr_valid, 0); chk("E_out", instr_out, 0);
        chk("E_ipc", instr_pc, 0); chk("E_busy", busy, 0); chk("E_done", done, 0);
        tick(); rst_n = 1;
        start_run();
        chk("E_restart_pc", pc, 0); chk("E_restart_busy", busy, 1);
        wait_vpc(0, "E_rewait");

        // F: halt while stalled with the skid buffer full
        halt_pulse(); start_run();
        wait_vpc(1, "F_wait");
        stall = 1; tick();
        chk("F_held", instr_pc, 1);
        halt = 1; tick(); halt = 0; stall = 0;
        chk("F_busy", busy, 0); chk("F_valid", instr_valid, 0); chk("F_done", done, 0);
        tick();
        chk("F_idle_valid", instr_valid, 0);
        start_run();
        chk("F_pc0", pc, 0);
        wait_vpc(0, "F_rewait");
        tick();
        chk("F_next", instr_pc, 1);

        // random phase, checked by the model each cycle
        halt_pulse();
        for (int c = 0; c < 3000; c++) begin
            start          = ($urandom_range(15) == 0);
            stall          = ($urandom_range(3) == 0);
            halt           = ($urandom_range(63) == 0);
            redirect_valid = ($urandom_range(19) == 0);
            redirect_pc    = 8'($urandom_range(11));
            tick();
        end
        start = 0; stall = 0; halt = 0; redirect_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
